// File: rtl/instr_fetch.sv
// Program counter and fetch stage: drives instruction-memory address, registers the
// fetched word into IR, applies taken branches with a one-slot squash, supports stall.
module instr_fetch #(
  parameter int unsigned          PC_W    = 10,
  parameter int unsigned          INSTR_W = 9,
  parameter int unsigned          OP_HI   = 8,
  parameter int unsigned          OP_W    = 3,
  parameter logic [OP_W-1:0]      HALT_OP = 3'b111
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic [PC_W-1:0]    ir_pc,
  output logic [OP_W-1:0]    opcode,
  output logic               done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]    ir_pc_q, ir_pc_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               halt_hit;

  assign halt_hit = valid_q && (ir_q[OP_HI -: OP_W] == HALT_OP);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    valid_d = valid_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          valid_d = 1'b0;
          done_d  = 1'b0;
        end
      end
      S_RUN: begin
        // Priority while advancing: halt, then branch squash, then sequential fetch.
        if (!stall) begin
          if (halt_hit) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            valid_d = 1'b0;
          end else if (branch_taken && valid_q) begin
            pc_d    = branch_target;
            valid_d = 1'b0;
          end else begin
            ir_d    = imem_data;
            ir_pc_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      ir_pc_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign ir_valid  = valid_q;
  assign ir_pc     = ir_pc_q;
  assign opcode    = ir_q[OP_HI -: OP_W];
  assign done      = done_q;

endmodule
